shift_add_mul: RTL and testbench
================================

Name: shift_add_mul

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier using shift-and-add. Each cycle it performs one add of the multiplicand into the upper half of the product register.
- Consumes the ripple-carry add datapath: one WIDTH-bit add with carry-out per iteration.
- Start/done handshake toward the surrounding lab datapath. Result is 2*WIDTH bits, held until the next start.

Parameters:
- WIDTH, 4, operand width in bits. Product is 2*WIDTH bits; iteration count is WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  multiplicand; captured on the accepted start edge
- b  input  WIDTH  multiplier; captured on the accepted start edge
- product  output  2*WIDTH  result register; valid while done=1, held afterwards
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). Reset clears state to IDLE, product=0, mcand=0, count=0, busy=0, done=0. Reset takes effect immediately, including mid-operation; the partial result is discarded.
- State register (registered; busy and done decode directly from it, no combinational input paths):
  - IDLE: busy=0, done=0.
  - CALC: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accept, in IDLE or DONE with start=1 at edge k:
  - mcand <= a.
  - product <= {WIDTH'b0, b}.
  - count <= 0.
  - state <= CALC.
- CALC, each edge:
  - If product[0]=1: {c, s} = product[2W-1:W] + mcand (WIDTH+1 bits), then product <= {c, s, product[W-1:1]}.
  - If product[0]=0: product <= {1'b0, product[2W-1:1]}.
  - count <= count + 1.
  - When count = WIDTH-1 on that edge, state <= DONE.
- Latency:
  - Iterations occur at edges k+1 .. k+WIDTH.
  - done=1 in the cycle following edge k+WIDTH; that is 4 iteration edges for WIDTH=4.
- DONE:
  - With start=0: state <= IDLE on the next edge; product held.
  - With start=1: new operands are accepted (back-to-back); done remains a single-cycle pulse.
- Boundary conditions:
  - start in CALC is ignored; operands are not re-sampled.
  - a or b changing during CALC has no effect.
  - Carry out of each add is never lost; max 15*15=225 fits in 8 bits.
  - count width is clog2(WIDTH)+1. It is unused in IDLE and DONE and holds its value there.
- Arithmetic is unsigned only; no overflow is possible.

Optional Feature:
- Macro: ZERO_SKIP_EN.
- Defined:
  - On accept, if a==0 or b==0: product <= 0 and state <= DONE directly.
  - done=1 in the cycle after edge k; CALC is skipped and busy never asserts.
- Undefined: zero operands take the full WIDTH iterations, giving product 0 with normal latency.

Decomposition:
- Package mul_pkg:
  - State encoding localparams: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - Default WIDTH constant.
  - Count-width function.
- Sub-module radd_w: WIDTH-bit ripple adder built from full-adder cells, returning sum plus carry-out. One instance per multiplier. The FSM, registers and shift logic stay in shift_add_mul.

Test Plan:
- Reset, then a=15, b=15, start pulse at edge k:
  - busy high for cycles k+1..k+4.
  - done pulse after edge k+4 with product=8'hE1 (225).
  - Returns to IDLE with product held.
- a=3, b=5 -> product=8'h0F; a=12, b=1 -> product=8'h0C; a=1, b=8 -> product=8'h08.
- Start with a=9, b=6; mid-CALC drive start=1 and a=2, b=2 -> product=8'h36 (54) and the extra start is ignored.
- In the done cycle, start=1 with a=7, b=7 -> second result 8'h31 (49); exactly two single-cycle done pulses.
- Assert rst at iteration 2 of a 13*11 multiply:
  - Immediately product=0, busy=0, done=0.
  - Fresh 13*11 afterwards gives 8'h8F (143).
- a=0, b=9:
  - Macro undefined: done after 4 iterations, product=0.
  - ZERO_SKIP_EN defined: done one cycle after the accept edge, busy never high, product=0.

Source files
------------

// File: rtl/shift_add_mul_pkg.sv
// Shared constants for the shift-and-add multiplier: state encoding, default
// operand width and the iteration-counter width helper.
package mul_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/shift_add_mul_radd.sv
// WIDTH-bit ripple-carry adder built from full-adder cells; sum plus carry-out.
module radd_w #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with start/done handshake.
// Optional ZERO_SKIP_EN: a zero operand finishes straight from the accept edge.
//
// state | meaning
// IDLE  | waiting for start, product held
// CALC  | one add/shift iteration per clock, busy=1
// DONE  | single-cycle done pulse, result valid; start here restarts back-to-back
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = cnt_w(WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             accept;
  logic             last;
  logic             skip_zero;

  radd_w #(.WIDTH(WIDTH)) u_radd (
    .x    (product[2*WIDTH-1:WIDTH]),
    .y    (mcand),
    .sum  (sum),
    .cout (carry)
  );

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (count == CW'(WIDTH - 1));

`ifdef ZERO_SKIP_EN
  assign skip_zero = (a == '0) || (b == '0);
`else
  assign skip_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_nxt = skip_zero ? DONE : CALC;
        else if (state == DONE) state_nxt = IDLE;
      end
      CALC:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // Carry-out lands in the product MSB on the same shift, so no add overflow is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
      mcand   <= '0;
      count   <= '0;
    end else if (accept) begin
      mcand   <= a;
      count   <= '0;
      product <= skip_zero ? '0 : {{WIDTH{1'b0}}, b};
    end else if (state == CALC) begin
      if (product[0]) product <= {carry, sum, product[WIDTH-1:1]};
      else            product <= {1'b0, product[2*WIDTH-1:1]};
      count <= count + CW'(1);
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul: driver pushes expected products, monitor
// pops and compares on every done pulse. Honours ZERO_SKIP_EN when defined.
module tb_shift_add_mul;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  shift_add_mul #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare product on each done pulse, and insist done never lasts two cycles.
  initial begin
    logic prev_done;
    logic [7:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("product", {24'd0, product}, {24'd0, e});
        end
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic [7:0] e);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at a negedge that is lat0 cycles after the accept edge; returns at the done negedge.
  task automatic wait_done(input int lat0, output int lat, output int bz);
    lat = lat0;
    bz = 0;
    while (!done && lat < 20) begin
      if (busy) bz++;
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_mul(input logic [3:0] ia, input logic [3:0] ib, input logic [7:0] e,
                        input int exp_lat, input int exp_bz);
    int lat, bz;
    issue(ia, ib, e);
    wait_done(1, lat, bz);
    chk("latency", lat, exp_lat);
    chk("busy_cycles", bz, exp_bz);
    @(negedge clk);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("held_product", {24'd0, product}, {24'd0, e});
  endtask

  initial begin
    int lat, bz, d0;

    #2;
    chk("rst_product", {24'd0, product}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_mul(4'd15, 4'd15, 8'hE1, 5, 4);
    do_mul(4'd3, 4'd5, 8'h0F, 5, 4);
    do_mul(4'd12, 4'd1, 8'h0C, 5, 4);
    do_mul(4'd1, 4'd8, 8'h08, 5, 4);

    // Start and new operands during CALC must be ignored.
    issue(4'd9, 4'd6, 8'h36);
    start = 1'b1;
    a = 4'd2;
    b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat, bz);
    chk("midcalc_latency", lat, 5);
    chk("midcalc_busy", bz, 3);
    @(negedge clk);
    chk("midcalc_idle", {31'd0, done}, 32'd0);

    // Back-to-back restart from the DONE cycle.
    d0 = done_cnt;
    issue(4'd2, 4'd3, 8'h06);
    wait_done(1, lat, bz);
    chk("b2b_first_latency", lat, 5);
    a = 4'd7;
    b = 4'd7;
    start = 1'b1;
    exp_q.push_back(8'h31);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_after_restart", {31'd0, busy}, 32'd1);
    wait_done(1, lat, bz);
    chk("b2b_second_latency", lat, 5);
    @(negedge clk);
    chk("b2b_done_pulses", done_cnt - d0, 2);

    // Reset mid-operation discards the partial result.
    @(negedge clk);
    a = 4'd13;
    b = 4'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_product", {24'd0, product}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_mul(4'd13, 4'd11, 8'h8F, 5, 4);

`ifdef ZERO_SKIP_EN
    do_mul(4'd0, 4'd9, 8'h00, 1, 0);
`else
    do_mul(4'd0, 4'd9, 8'h00, 5, 4);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
